// File: rtl/elixirchip_es1_spu_op_mem_sp_arbiter.sv
// elixirchip_es1_spu_op_mem_sp_arbiter: round-robin arbiter sharing one single-port memory among NUM_PORTS requesters
// Ports: reset/clk/cke; per-port s_valid/s_we/s_addr/s_wdata with one-hot s_ready;
// registered mem_addr/mem_wdata/mem_wvalid toward the memory, mem_rdata back from it;
// shared m_rdata plus one-hot m_rvalid per port.
// Macro ELIXIRCHIP_ES1_SPU_OP_MEM_SP_ARBITER_RDATA_REG_EN registers m_rdata and adds one tag stage.
module elixirchip_es1_spu_op_mem_sp_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int LATENCY   = 2,
  parameter int DATA_BITS = 18,
  parameter int ADDR_BITS = 10
) (
  input  logic                           reset,
  input  logic                           clk,
  input  logic                           cke,
  input  logic [NUM_PORTS-1:0]           s_valid,
  input  logic [NUM_PORTS-1:0]           s_we,
  input  logic [NUM_PORTS*ADDR_BITS-1:0] s_addr,
  input  logic [NUM_PORTS*DATA_BITS-1:0] s_wdata,
  output logic [NUM_PORTS-1:0]           s_ready,
  output logic [ADDR_BITS-1:0]           mem_addr,
  output logic [DATA_BITS-1:0]           mem_wdata,
  output logic                           mem_wvalid,
  input  logic [DATA_BITS-1:0]           mem_rdata,
  output logic [DATA_BITS-1:0]           m_rdata,
  output logic [NUM_PORTS-1:0]           m_rvalid
);
  localparam int PW = $clog2(NUM_PORTS);
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_SP_ARBITER_RDATA_REG_EN
  localparam int DEPTH = 2 + LATENCY;
`else
  localparam int DEPTH = 1 + LATENCY;
`endif
  logic [PW-1:0]                     r_ptr;
  logic [ADDR_BITS-1:0]              r_addr;
  logic [DATA_BITS-1:0]              r_wdata;
  logic                              r_wvalid;
  logic [DEPTH-1:0][NUM_PORTS-1:0]   r_tag;
  logic                              w_any;
  logic [PW-1:0]                     w_gnt;
  logic [PW-1:0]                     w_idx;
  logic [PW:0]                       w_sum;
  logic [PW-1:0]                     w_nptr;
  logic [NUM_PORTS-1:0]              w_onehot;
  logic                              w_accept;
  logic                              w_rd;
  // Scan requesters starting at the pointer, wrapping modulo NUM_PORTS; first hit wins.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_sum = '0;
    w_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      w_idx = PW'(w_sum >= (PW+1)'(NUM_PORTS) ? w_sum - (PW+1)'(NUM_PORTS) : w_sum);
      if (!w_any && s_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end
  assign w_onehot = NUM_PORTS'(1) << w_gnt;
  assign w_accept = cke && w_any;
  assign w_rd     = w_accept && !s_we[w_gnt];
  assign w_nptr   = (w_gnt == PW'(NUM_PORTS - 1)) ? '0 : w_gnt + 1'b1;
  assign s_ready  = w_accept ? w_onehot : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wvalid <= 1'b0;
      r_tag    <= '0;
    end else if (cke) begin
      r_wvalid <= w_accept && s_we[w_gnt];
      if (w_any) begin
        r_ptr   <= w_nptr;
        r_addr  <= s_addr[int'(w_gnt)*ADDR_BITS +: ADDR_BITS];
        r_wdata <= s_wdata[int'(w_gnt)*DATA_BITS +: DATA_BITS];
      end
      // Tag pipeline tracks which port owns each in-flight read.
      r_tag <= {r_tag[DEPTH-2:0], (w_rd ? w_onehot : NUM_PORTS'(0))};
    end
  end
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_wvalid = r_wvalid;
  assign m_rvalid   = r_tag[DEPTH-1];
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_SP_ARBITER_RDATA_REG_EN
  logic [DATA_BITS-1:0] r_rdata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rdata <= '0;
    else if (cke) r_rdata <= mem_rdata;
  end
  assign m_rdata = r_rdata;
`else
  assign m_rdata = mem_rdata;
`endif
endmodule

// File: tb/tb_elixirchip_es1_spu_op_mem_sp_arbiter.sv
// tb_elixirchip_es1_spu_op_mem_sp_arbiter: directed self-checking bench for the memory arbiter
module tb_elixirchip_es1_spu_op_mem_sp_arbiter;
  localparam int N = 4;
  localparam int L = 2;
  localparam int D = 18;
  localparam int A = 10;
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_SP_ARBITER_RDATA_REG_EN
  localparam int RL = 2 + L;
`else
  localparam int RL = 1 + L;
`endif
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cke = 1'b1;
  logic [N-1:0]   s_valid = '0;
  logic [N-1:0]   s_we = '0;
  logic [N*A-1:0] s_addr = '0;
  logic [N*D-1:0] s_wdata = '0;
  logic [N-1:0]   s_ready;
  logic [A-1:0]   mem_addr;
  logic [D-1:0]   mem_wdata;
  logic           mem_wvalid;
  logic [D-1:0]   mem_rdata;
  logic [D-1:0]   m_rdata;
  logic [N-1:0]   m_rvalid;
  int checks = 0;
  int failures = 0;
  logic [D-1:0] mem [1024];
  logic [D-1:0] mem_r1;
  elixirchip_es1_spu_op_mem_sp_arbiter #(
    .NUM_PORTS(N), .LATENCY(L), .DATA_BITS(D), .ADDR_BITS(A)
  ) dut (
    .reset(reset), .clk(clk), .cke(cke),
    .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_ready(s_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_rdata(mem_rdata),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid)
  );
  always #5 clk = ~clk;
  // Behavioural single-port memory with LATENCY=2 enabled cycles of read latency.
  always @(posedge clk) begin
    if (cke) begin
      if (mem_wvalid) mem[mem_addr] <= mem_wdata;
      mem_r1    <= mem[mem_addr];
      mem_rdata <= mem_r1;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++; if (s_ready !== 4'b0000) begin failures++; $display("FAIL idle_s_ready cyc=%0d got=%b exp=0000", i, s_ready); end
      checks++; if (m_rvalid !== 4'b0000) begin failures++; $display("FAIL idle_m_rvalid cyc=%0d got=%b exp=0000", i, m_rvalid); end
      checks++; if (mem_wvalid !== 1'b0) begin failures++; $display("FAIL idle_mem_wvalid cyc=%0d got=%b exp=0", i, mem_wvalid); end
      tick();
    end
    checks++; if (mem_addr !== 10'h000) begin failures++; $display("FAIL rst_mem_addr got=%h exp=000", mem_addr); end
    checks++; if (mem_wdata !== 18'h00000) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=00000", mem_wdata); end
    s_valid = 4'hF;
    #1;
    checks++; if (s_ready !== 4'b0001) begin failures++; $display("FAIL rst_ptr_grant got=%b exp=0001", s_ready); end
    s_valid = 4'h0;
  endtask
  task automatic test_write_read;
    s_addr[2*A +: A] = 10'h03A;
    s_wdata[2*D +: D] = 18'h00155;
    s_addr[0 +: A] = 10'h03A;
    s_valid = 4'b0100; s_we = 4'b0100;
    #1;
    checks++; if (s_ready !== 4'b0100) begin failures++; $display("FAIL wr_grant got=%b exp=0100", s_ready); end
    tick();
    checks++; if (mem_wvalid !== 1'b1) begin failures++; $display("FAIL wr_mem_wvalid got=%b exp=1", mem_wvalid); end
    checks++; if (mem_addr !== 10'h03A) begin failures++; $display("FAIL wr_mem_addr got=%h exp=03a", mem_addr); end
    checks++; if (mem_wdata !== 18'h00155) begin failures++; $display("FAIL wr_mem_wdata got=%h exp=00155", mem_wdata); end
    s_valid = 4'b0001; s_we = 4'b0000;
    #1;
    checks++; if (s_ready !== 4'b0001) begin failures++; $display("FAIL rd_grant got=%b exp=0001", s_ready); end
    tick();
    s_valid = 4'b0000;
    checks++; if (mem_wvalid !== 1'b0) begin failures++; $display("FAIL rd_mem_wvalid got=%b exp=0", mem_wvalid); end
    for (int i = 1; i <= RL + 1; i++) begin
      #1;
      checks++; if (m_rvalid !== (i == RL ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL rd_rvalid cyc=%0d got=%b exp=%b", i, m_rvalid, (i == RL ? 4'b0001 : 4'b0000)); end
      if (i == RL) begin
        checks++; if (m_rdata !== 18'h00155) begin failures++; $display("FAIL rd_rdata got=%h exp=00155", m_rdata); end
      end
      tick();
    end
  endtask
  task automatic test_round_robin;
    logic [N-1:0] exp_r, exp_v;
    s_valid = 4'b1000; s_we = 4'b1000;
    tick();
    for (int i = 0; i < 8 + RL; i++) begin
      s_valid = (i < 8) ? 4'hF : 4'h0; s_we = 4'h0;
      #1;
      exp_r = (i < 8) ? 4'(1 << (i % 4)) : 4'b0000;
      exp_v = (i >= RL) ? 4'(1 << ((i - RL) % 4)) : 4'b0000;
      checks++; if (s_ready !== exp_r) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, s_ready, exp_r); end
      checks++; if (m_rvalid !== exp_v) begin failures++; $display("FAIL rr_rvalid cyc=%0d got=%b exp=%b", i, m_rvalid, exp_v); end
      tick();
    end
  endtask
  task automatic test_ptr_wrap;
    s_addr[1*A +: A] = 10'h011;
    s_addr[3*A +: A] = 10'h2C3;
    s_wdata[3*D +: D] = 18'h2ABCD;
    s_valid = 4'b0010; s_we = 4'b1010;
    tick();
    s_valid = 4'b1010;
    #1;
    checks++; if (s_ready !== 4'b1000) begin failures++; $display("FAIL wrap_grant3 got=%b exp=1000", s_ready); end
    tick();
    checks++; if (mem_addr !== 10'h2C3) begin failures++; $display("FAIL wrap_mem_addr got=%h exp=2c3", mem_addr); end
    checks++; if (mem_wdata !== 18'h2ABCD) begin failures++; $display("FAIL wrap_mem_wdata got=%h exp=2abcd", mem_wdata); end
    #1;
    checks++; if (s_ready !== 4'b0010) begin failures++; $display("FAIL wrap_grant1 got=%b exp=0010", s_ready); end
    tick();
    s_valid = 4'b0000; s_we = 4'b0000;
  endtask
  task automatic test_cke;
    s_valid = 4'b0001; s_we = 4'b0000;
    #1;
    checks++; if (s_ready !== 4'b0001) begin failures++; $display("FAIL cke_grant got=%b exp=0001", s_ready); end
    tick();
    cke = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (s_ready !== 4'b0000) begin failures++; $display("FAIL cke_low_ready cyc=%0d got=%b exp=0000", i, s_ready); end
      checks++; if (m_rvalid !== 4'b0000) begin failures++; $display("FAIL cke_low_rvalid cyc=%0d got=%b exp=0000", i, m_rvalid); end
      tick();
    end
    cke = 1'b1; s_valid = 4'b0000;
    for (int j = 1; j < RL; j++) begin
      #1;
      checks++; if (m_rvalid !== 4'b0000) begin failures++; $display("FAIL cke_early_rvalid j=%0d got=%b exp=0000", j, m_rvalid); end
      tick();
    end
    checks++; if (m_rvalid !== 4'b0001) begin failures++; $display("FAIL cke_rvalid got=%b exp=0001", m_rvalid); end
    checks++; if (m_rdata !== 18'h00155) begin failures++; $display("FAIL cke_rdata got=%h exp=00155", m_rdata); end
    tick();
    checks++; if (m_rvalid !== 4'b0000) begin failures++; $display("FAIL cke_rvalid_drop got=%b exp=0000", m_rvalid); end
  endtask
  task automatic test_reset_mid;
    s_valid = 4'b0100; s_we = 4'b0000;
    #1;
    checks++; if (s_ready !== 4'b0100) begin failures++; $display("FAIL rm_grant got=%b exp=0100", s_ready); end
    tick();
    s_valid = 4'b0000;
    tick();
    reset = 1'b1;
    #1;
    checks++; if (m_rvalid !== 4'b0000) begin failures++; $display("FAIL rm_rvalid_in_reset got=%b exp=0000", m_rvalid); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (m_rvalid !== 4'b0000) begin failures++; $display("FAIL rm_rvalid cyc=%0d got=%b exp=0000", i, m_rvalid); end
      tick();
    end
    s_valid = 4'b1010;
    #1;
    checks++; if (s_ready !== 4'b0010) begin failures++; $display("FAIL rm_first_grant got=%b exp=0010", s_ready); end
    tick();
    s_valid = 4'b0000;
    tick();
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_ptr_wrap();
    test_cke();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
